// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue stage: opcodes, ALU select codes, FSM states, issue payload.
package alu_issue_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned SEL_W = 4;
    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [SEL_W-1:0] S_SLL  = 4'b0000;
    localparam logic [SEL_W-1:0] S_SR   = 4'b0001;
    localparam logic [SEL_W-1:0] S_ADD  = 4'b0010;
    localparam logic [SEL_W-1:0] S_AND  = 4'b0011;
    localparam logic [SEL_W-1:0] S_OR   = 4'b0100;
    localparam logic [SEL_W-1:0] S_XOR  = 4'b0101;
    localparam logic [SEL_W-1:0] S_SLT  = 4'b0110;
    localparam logic [SEL_W-1:0] S_MUL  = 4'b0111;
    localparam logic [SEL_W-1:0] S_MULH = 4'b1000;
    localparam logic [SEL_W-1:0] S_DIV  = 4'b1001;
    localparam logic [SEL_W-1:0] S_REM  = 4'b1010;
    localparam logic [SEL_W-1:0] S_SUB  = 4'b1011;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } issue_state_e;

    typedef struct packed {
        logic [XLEN-1:0]  x;
        logic [XLEN-1:0]  y;
        logic [SEL_W-1:0] s;
        logic             un;
        logic [REG_W-1:0] rd;
        logic             wb_en;
    } alu_op_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32 decode of OP / OP-IMM / LUI / AUIPC into ALU operands and select.
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [XLEN-1:0]  instr,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic [XLEN-1:0]  X,
    output logic [XLEN-1:0]  Y,
    output logic [SEL_W-1:0] S,
    output logic             un,
    output logic [REG_W-1:0] rd,
    output logic             legal
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_shamt;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign w_shamt  = {{(XLEN-5){1'b0}}, instr[24:20]};
    assign rd       = instr[11:7];

    always_comb begin
        X     = rs1_data;
        Y     = rs2_data;
        S     = S_ADD;
        un    = 1'b0;
        legal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                case (w_funct7)
                    7'b0000000: begin
                        legal = 1'b1;
                        case (w_funct3)
                            3'b000:  S = S_ADD;
                            3'b001:  S = S_SLL;
                            3'b010:  S = S_SLT;
                            3'b011:  begin S = S_SLT; un = 1'b1; end
                            3'b100:  S = S_XOR;
                            3'b101:  begin S = S_SR; un = 1'b1; end
                            3'b110:  S = S_OR;
                            default: S = S_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (w_funct3)
                            3'b000:  begin S = S_SUB; legal = 1'b1; end
                            3'b101:  begin S = S_SR;  legal = 1'b1; end
                            default: legal = 1'b0;
                        endcase
                    end
                    // Only the signed M-extension subset is supported.
                    7'b0000001: begin
                        case (w_funct3)
                            3'b000:  begin S = S_MUL;  legal = 1'b1; end
                            3'b001:  begin S = S_MULH; legal = 1'b1; end
                            3'b100:  begin S = S_DIV;  legal = 1'b1; end
                            3'b110:  begin S = S_REM;  legal = 1'b1; end
                            default: legal = 1'b0;
                        endcase
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                Y = w_imm_i;
                case (w_funct3)
                    3'b000: begin S = S_ADD; legal = 1'b1; end
                    3'b010: begin S = S_SLT; legal = 1'b1; end
                    3'b011: begin S = S_SLT; un = 1'b1; legal = 1'b1; end
                    3'b100: begin S = S_XOR; legal = 1'b1; end
                    3'b110: begin S = S_OR;  legal = 1'b1; end
                    3'b111: begin S = S_AND; legal = 1'b1; end
                    3'b001: begin
                        Y     = w_shamt;
                        S     = S_SLL;
                        legal = (w_funct7 == 7'b0000000);
                    end
                    default: begin
                        Y     = w_shamt;
                        S     = S_SR;
                        un    = (w_funct7 == 7'b0000000);
                        legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                    end
                endcase
            end
            OPC_LUI: begin
                X     = '0;
                Y     = {instr[31:12], 12'b0};
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                X     = pc;
                Y     = {instr[31:12], 12'b0};
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: one-entry registered skid toward EX, with sticky illegal-instruction trap.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  instr,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  X,
    output logic [XLEN-1:0]  Y,
    output logic [SEL_W-1:0] S,
    output logic             un,
    output logic [REG_W-1:0] rd,
    output logic             wb_en,
    output logic             trap,
    output logic [XLEN-1:0]  trap_pc,
    input  logic             trap_ack
);

    issue_state_e     r_state;
    issue_state_e     w_state_nxt;
    logic             r_trap;
    logic [XLEN-1:0]  r_trap_pc;
    logic [XLEN-1:0]  w_trap_pc_nxt;
    logic             r_out_valid;
    alu_op_t          r_op;
    alu_op_t          w_dec;
    logic [XLEN-1:0]  w_x;
    logic [XLEN-1:0]  w_y;
    logic [SEL_W-1:0] w_s;
    logic             w_un;
    logic [REG_W-1:0] w_rd;
    logic             w_legal;
    logic             w_in_fire;
    logic             w_out_fire;

    alu_decode u_decode (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .X        (w_x),
        .Y        (w_y),
        .S        (w_s),
        .un       (w_un),
        .rd       (w_rd),
        .legal    (w_legal)
    );

    assign w_dec      = '{x: w_x, y: w_y, s: w_s, un: w_un, rd: w_rd, wb_en: (w_rd != '0)};
    assign in_ready   = (r_state == ST_RUN) && (!r_out_valid || out_ready) && !flush;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // Next-state: an accepted illegal instruction traps; only trap_ack leaves TRAP.
    always_comb begin
        w_state_nxt   = r_state;
        w_trap_pc_nxt = r_trap_pc;
        case (r_state)
            ST_RUN: begin
                if (w_in_fire && !w_legal) begin
                    w_state_nxt   = ST_TRAP;
                    w_trap_pc_nxt = pc;
                end
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RUN;
            r_trap    <= 1'b0;
            r_trap_pc <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_trap    <= (w_state_nxt == ST_TRAP);
            r_trap_pc <= w_trap_pc_nxt;
        end
    end

    // Entry register: illegal instructions never load, flush always empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_op        <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_in_fire && w_legal) begin
            r_out_valid <= 1'b1;
            r_op        <= w_dec;
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign X         = r_op.x;
    assign Y         = r_op.y;
    assign S         = r_op.s;
    assign un        = r_op.un;
    assign rd        = r_op.rd;
    assign wb_en     = r_op.wb_en;
    assign trap      = r_trap;
    assign trap_pc   = r_trap_pc;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed instructions, monitor checks every out transfer.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] X;
    logic [31:0] Y;
    logic [3:0]  S;
    logic        un;
    logic [4:0]  rd;
    logic        wb_en;
    logic        trap;
    logic [31:0] trap_pc;
    logic        trap_ack;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [3:0]  s;
        logic        un;
        logic [4:0]  rd;
        logic        wb;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    alu_issue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .X        (X),
        .Y        (Y),
        .S        (S),
        .un       (un),
        .rd       (rd),
        .wb_en    (wb_en),
        .trap     (trap),
        .trap_pc  (trap_pc),
        .trap_ack (trap_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] x, input logic [31:0] y, input logic [3:0] s,
                                input logic u, input logic [4:0] r, input logic w);
        exp_t e;
        e.x = x; e.y = y; e.s = s; e.un = u; e.rd = r; e.wb = w;
        return e;
    endfunction

    // Offer an instruction expected to be accepted this cycle; leaves in_valid high.
    task automatic offer(input string nm, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b, input exp_t e);
        in_valid = 1'b1; instr = ins; pc = p; rs1_data = a; rs2_data = b;
        #1;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        sb.push_back(e);
        tick();
    endtask

    task automatic chk_entry(input string nm, input exp_t e);
        chk({nm, "_X"}, X, e.x);
        chk({nm, "_Y"}, Y, e.y);
        chk({nm, "_S"}, 32'(S), 32'(e.s));
        chk({nm, "_un"}, 32'(un), 32'(e.un));
        chk({nm, "_rd"}, 32'(rd), 32'(e.rd));
        chk({nm, "_wb_en"}, 32'(wb_en), 32'(e.wb));
    endtask

    task automatic chk_reset(input string nm);
        exp_t z;
        z = mk(32'h0, 32'h0, 4'h0, 1'b0, 5'd0, 1'b0);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_trap"}, 32'(trap), 32'd0);
        chk({nm, "_trap_pc"}, trap_pc, 32'h0);
        chk_entry(nm, z);
    endtask

    // Monitor: every out transfer must match the oldest scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got transfer S=%0h rd=%0d expected none at %0t", S, rd, $time);
                end else begin
                    chk_entry("mon", sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e_sub;
        exp_t e_srli;
        exp_t e_auipc;

        rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        flush = 1'b0; out_ready = 1'b1; trap_ack = 1'b0;
        #12;
        chk_reset("reset");
        tick();
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // add x3,x1,x2 then a back-to-back burst at full throughput
        offer("add",   32'h002081B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'b0010, 1'b0, 5'd3, 1'b1));
        offer("srai",  32'h4030D213, 32'h4, 32'h8000_0010, 32'd9,
              mk(32'h8000_0010, 32'd3, 4'b0001, 1'b0, 5'd4, 1'b1));
        offer("sltu",  32'h0020B2B3, 32'h8, 32'h8000_0010, 32'd9,
              mk(32'h8000_0010, 32'd9, 4'b0110, 1'b1, 5'd5, 1'b1));
        offer("addi0", 32'hFFF08013, 32'hC, 32'd1, 32'd2,
              mk(32'd1, 32'hFFFF_FFFF, 4'b0010, 1'b0, 5'd0, 1'b0));
        offer("lui",   32'hABCDE3B7, 32'h10, 32'd1, 32'd2,
              mk(32'h0, 32'hABCDE000, 4'b0010, 1'b0, 5'd7, 1'b1));
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        // Hold: entry must stay put and in_ready low while out_ready is low
        out_ready = 1'b0;
        e_sub  = mk(32'd100, 32'd30, 4'b1011, 1'b0, 5'd8, 1'b1);
        e_srli = mk(32'd100, 32'd31, 4'b0001, 1'b1, 5'd9, 1'b1);
        offer("sub", 32'h40208433, 32'h20, 32'd100, 32'd30, e_sub);
        instr = 32'h01F0D493;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk_entry("hold", e_sub);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("replace_in_ready", 32'(in_ready), 32'd1);
        sb.push_back(e_srli);
        tick();
        in_valid = 1'b0;
        chk("replace_out_valid", 32'(out_valid), 32'd1);
        tick();

        // divu is illegal: trap, nothing issued
        in_valid = 1'b1; instr = 32'h0220D333; pc = 32'h40;
        tick();
        in_valid = 1'b0;
        chk("trap", 32'(trap), 32'd1);
        chk("trap_pc", trap_pc, 32'h40);
        chk("trap_in_ready", 32'(in_ready), 32'd0);
        chk("trap_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1; instr = 32'h002081B3; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("trap_after_flush", 32'(trap), 32'd1);
        chk("trap_flush_out_valid", 32'(out_valid), 32'd0);
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        chk("trap_cleared", 32'(trap), 32'd0);
        chk("run_in_ready", 32'(in_ready), 32'd1);

        // Flush with held entry and a concurrent offer
        out_ready = 1'b0;
        offer("flush_add", 32'h002081B3, 32'h50, 32'd1, 32'd2, mk(32'd1, 32'd2, 4'b0010, 1'b0, 5'd3, 1'b1));
        instr = 32'h0020B2B3; flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        void'(sb.pop_back());
        out_ready = 1'b1;
        tick();
        chk("flush_no_accept", 32'(out_valid), 32'd0);

        // auipc then asynchronous reset while held
        out_ready = 1'b0;
        e_auipc = mk(32'h100, 32'h12345000, 4'b0010, 1'b0, 5'd1, 1'b1);
        offer("auipc", 32'h12345097, 32'h100, 32'd77, 32'd88, e_auipc);
        in_valid = 1'b0;
        chk("auipc_out_valid", 32'(out_valid), 32'd1);
        chk_entry("auipc", e_auipc);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        sb.delete();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_reset_out_valid", 32'(out_valid), 32'd0);
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, ports listed first below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  upstream offers instr/pc/rs1_data/rs2_data this cycle.
REQ-005 in_ready  output  1  block accepts the offer this cycle.
REQ-006 instr  input  32  RV32 instruction word.
REQ-007 pc  input  32  address of instr.
REQ-008 rs1_data, rs2_data  input  32 each  register-file read values.
REQ-009 flush  input  1  discard held entry and any offer this cycle.
REQ-010 out_valid  output  1  registered ALU operation is present.
REQ-011 out_ready  input  1  ALU/EX consumer takes the entry this cycle.
REQ-012 X, Y  output  32 each  ALU operands.
REQ-013 S  output  4  ALU operation select.
REQ-014 un  output  1  ALU unsigned-variant select.
REQ-015 rd  output  5  destination register.
REQ-016 wb_en  output  1  result to be written back (0 when rd==0).
REQ-017 trap  output  1  illegal-instruction indication, sticky.
REQ-018 trap_pc  output  32  pc of the offending instruction.
REQ-019 trap_ack  input  1  clears trap.

Function
REQ-020 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-021 in_ready SHALL be (state==RUN) && (!out_valid || out_ready) && !flush, combinational, giving full throughput with 1-cycle latency.
REQ-022 The FSM SHALL have states RUN and TRAP: RUN->TRAP on an accepted illegal instruction; TRAP->RUN on trap_ack; flush SHALL NOT leave TRAP.
REQ-023 Decode, OP (0110011): funct7=0000000 f3 001 sll S=0000, 101 srl S=0001 un=1, 000 add 0010, 111 and 0011, 110 or 0100, 100 xor 0101, 010 slt 0110 un=0, 011 sltu 0110 un=1; funct7=0100000 f3 000 sub 1011, 101 sra 0001 un=0; funct7=0000001 f3 000 mul 0111, 001 mulh 1000, 100 div 1001, 110 rem 1010; X=rs1_data, Y=rs2_data.
REQ-024 OP-IMM (0010011) SHALL map addi/slti/sltiu/xori/ori/andi/slli/srli/srai to the same S/un, X=rs1_data, Y=sign-extended imm[11:0]; shifts use Y[4:0]=instr[24:20] and require instr[31:25] 0000000 (srai 0100000).
REQ-025 LUI (0110111) SHALL issue X=0, Y={instr[31:12],12'b0}, S=0010; AUIPC (0010111) SHALL issue X=pc, same Y, S=0010.
REQ-026 Any other opcode/funct combination (incl. mulhsu, mulhu, divu, remu) SHALL be illegal: not issued, out_valid unchanged, trap=1, trap_pc=pc.
REQ-027 un SHALL be 0 for every operation not listed with un=1.
REQ-028 wb_en SHALL be 1 for every issued operation with rd!=0, else 0.
REQ-029 Held outputs SHALL remain stable while out_valid && !out_ready.
REQ-030 flush SHALL clear out_valid next cycle regardless of out_ready; an offer during flush SHALL NOT be accepted.
REQ-031 Simultaneous out transfer and in transfer SHALL replace the entry with out_valid staying 1.

Reset
REQ-032 On rst_n low: state=RUN, out_valid=0, trap=0, trap_pc=0, X=Y=0, S=0000, un=0, rd=0, wb_en=0, asynchronously; reset mid-transfer SHALL discard the entry.

Structure
REQ-033 Opcode constants, the 4-bit S encodings and FSM state encoding SHALL live in a shared package also used by the ALU.
REQ-034 Decode SHALL be one combinational sub-module alu_decode (instr, pc, rs1_data, rs2_data -> X, Y, S, un, rd, legal); alu_issue holds the register, handshake and FSM.

Verification
REQ-035 Reset, then add x3,x1,x2 with rs1=5, rs2=7 -> next cycle out_valid=1, X=5, Y=7, S=0010, un=0, rd=3, wb_en=1.
REQ-036 srai x4,x1,3 then sltu x5,x1,x2 back-to-back, out_ready=1 -> S=0001 un=0 Y=3, then S=0110 un=1, one per cycle.
REQ-037 out_ready=0 for 3 cycles with held entry -> in_ready=0, outputs unchanged; out_ready=1 with new offer -> replaced, out_valid stays 1.
REQ-038 divu offered at pc=0x40 -> trap=1, trap_pc=0x40, in_ready=0, out_valid unchanged; trap_ack -> RUN.
REQ-039 flush with held entry and concurrent offer -> out_valid=0 next cycle, offer not accepted.
REQ-040 auipc x1,0x12345 at pc=0x100 then rst_n low mid-hold -> X=0x100, Y=0x12345000, then all outputs at reset values.
